// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: datapath widths, the fetch
// FSM state type and the canonical NOP encoding.
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and decode. Synchronous flush,
// simultaneous push/pop allowed even when full; head reads zero when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    // DEPTH is a power of two, so the pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, buffers in-order
// responses for decode, and discards responses orphaned by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   MAX_OUT_W = CW'(MAX_OUT);
    localparam logic [XLEN-1:0] START_PC  = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e         state, state_n;
    logic [XLEN-1:0]      fetch_pc, resp_pc, target;
    logic [CW-1:0]        outstanding, kill, in_flight, kill_redir, count;
    logic [CW:0]          occupancy;
    logic                 started, grant, rsp, live_rsp, push, empty, full;
    logic [XLEN+ILEN-1:0] head;

    assign target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign grant      = imem_req && imem_gnt;
    assign in_flight  = outstanding + kill;
    // Responses with nothing in flight belong to requests abandoned by reset.
    assign rsp        = imem_rvalid && (in_flight != '0);
    assign live_rsp   = rsp && (state == FETCH) && !redirect;
    assign push       = live_rsp && !(full && !if_ready);
    assign kill_redir = in_flight - CW'(rsp) + CW'(grant);
    assign occupancy  = {1'b0, count} + {1'b0, outstanding};
    assign imem_addr  = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        case (state)
            FETCH: imem_req = started && !redirect &&
                              (occupancy < DEPTH_W) && (outstanding < MAX_OUT_W);
            FLUSH: if (rsp && kill == CW'(1)) state_n = FETCH;
            default: state_n = FETCH;
        endcase
        if (redirect) state_n = (kill_redir != '0) ? FLUSH : FETCH;
    end

    // started holds imem_req low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            outstanding <= '0;
            kill        <= '0;
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect) begin
                fetch_pc    <= target;
                resp_pc     <= target;
                outstanding <= '0;
                kill        <= kill_redir;
            end else begin
                if (grant)    fetch_pc <= fetch_pc + 32'd4;
                if (live_rsp) resp_pc  <= resp_pc + 32'd4;
                outstanding <= outstanding + CW'(grant) - CW'(live_rsp);
                if (state == FLUSH && rsp) kill <= kill - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH(XLEN + ILEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(redirect),
        .push (push),
        .pop  (if_ready),
        .wdata({resp_pc, imem_rdata}),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign if_valid = !empty;
    assign {if_pc, if_instr} = head;
endmodule
